host_bus_arbiter: RTL

HOST_BUS_ARBITER -- requirements
Module: host_bus_arbiter

---
 rtl/host_bus_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/host_bus_arbiter.sv
// Round-robin arbiter sharing one simple host-bus master among NUM_REQ requesters.
// One transaction in flight at a time: IDLE -> ISSUE -> (WAIT) -> CLEAR -> IDLE.
module host_bus_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NUM_REQ-1:0][1:0]  i_req_rw,
  input  logic [NUM_REQ-1:0][2:0]  i_req_size,
  input  logic [NUM_REQ-1:0][31:0] i_req_addr,
  input  logic [NUM_REQ-1:0][63:0] i_req_wdata,
  output logic [NUM_REQ-1:0]       o_gnt,
  output logic [NUM_REQ-1:0]       o_resp_valid,
  output logic [63:0]              o_resp_rdata,
  output logic                     o_resp_error,
  output logic                     o_resp_invalid,
  output logic [1:0]               o_m_rw,
  output logic [2:0]               o_m_size,
  output logic [31:0]              o_m_addr,
  output logic [63:0]              o_m_wdata,
  output logic                     o_m_clear,
  input  logic                     i_m_wait,
  input  logic                     i_m_done,
  input  logic                     i_m_error,
  input  logic                     i_m_invalid,
  input  logic [63:0]              i_m_rdata
);
  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CLEAR} state_t;

  state_t             state, state_nxt;
  logic [NUM_REQ-1:0] pend;
  logic [NUM_REQ-1:0] gnt;
  logic [IW-1:0]      rr_ptr, sel_idx;
  logic               sel_vld, cmpl;
  logic [1:0]         lat_rw;
  logic [2:0]         lat_size;
  logic [31:0]        lat_addr;
  logic [63:0]        lat_wdata;
  logic [63:0]        resp_rdata;
  logic               resp_error, resp_invalid;
  int                 cand;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_pend
    assign pend[k] = (i_req_rw[k] == 2'b01) || (i_req_rw[k] == 2'b10);
  end

  // Scan offsets high to low so the smallest offset from rr_ptr is the last writer.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    cand    = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = int'(rr_ptr) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (pend[IW'(cand)]) begin
        sel_vld = 1'b1;
        sel_idx = IW'(cand);
      end
    end
  end

  assign cmpl = i_m_done && !i_m_wait;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sel_vld) state_nxt = ISSUE;
      ISSUE:   state_nxt = cmpl ? CLEAR : WAIT;
      WAIT:    if (cmpl) state_nxt = CLEAR;
      CLEAR:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rr_ptr       <= '0;
      gnt          <= '0;
      lat_rw       <= '0;
      lat_size     <= '0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      resp_rdata   <= '0;
      resp_error   <= 1'b0;
      resp_invalid <= 1'b0;
    end else begin
      if (state == IDLE && sel_vld) begin
        gnt       <= NUM_REQ'(1) << sel_idx;
        lat_rw    <= i_req_rw[sel_idx];
        lat_size  <= i_req_size[sel_idx];
        lat_addr  <= i_req_addr[sel_idx];
        lat_wdata <= i_req_wdata[sel_idx];
        rr_ptr    <= (sel_idx == IW'(NUM_REQ - 1)) ? '0 : sel_idx + IW'(1);
      end
      if ((state == ISSUE || state == WAIT) && cmpl) begin
        resp_error   <= i_m_error;
        resp_invalid <= i_m_invalid;
        resp_rdata   <= (lat_rw == 2'b10) ? i_m_rdata : '0;
      end
      if (state == CLEAR) gnt <= '0;
    end
  end

  assign o_gnt          = gnt;
  assign o_resp_valid   = (state == CLEAR) ? gnt : '0;
  assign o_m_clear      = (state == CLEAR);
  assign o_m_rw         = (state == ISSUE) ? lat_rw : 2'b00;
  assign o_m_size       = lat_size;
  assign o_m_addr       = lat_addr;
  assign o_m_wdata      = lat_wdata;
  assign o_resp_rdata   = resp_rdata;
  assign o_resp_error   = resp_error;
  assign o_resp_invalid = resp_invalid;

endmodule
